// File: rtl/edl_capture_stage_if.sv
// rtl/edl_capture_stage_if.sv - strobe/data bundle between stage controller, datapath and capture stage
interface edl_capture_stage_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  logic             latch_en;
  logic             sample;
  logic [W-1:0]     data_in;
  logic [W-1:0]     data_out;
  logic             err0;
  logic             err1;
  logic             protocol_err;
  logic [CNT_W-1:0] err_count;

  // Controller/datapath side: drives strobes and stage data, observes the result
  modport master (
    output latch_en, sample, data_in,
    input  data_out, err0, err1, protocol_err, err_count
  );

  // Capture stage side
  modport slave (
    input  latch_en, sample, data_in,
    output data_out, err0, err1, protocol_err, err_count
  );
endinterface

// File: rtl/edl_capture_stage.sv
// rtl/edl_capture_stage.sv - error-detecting capture register with dual-rail report; EDL_ERR_COUNT_EN builds the error counter
module edl_capture_stage #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst,
  edl_capture_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t         state, state_d;
  logic           latch_q, sample_q;
  logic           lrise, srise, sfall;
  logic [W-1:0]   main, main_d;
  logic           late, late_d;
  logic           err0, err0_d;
  logic           err1, err1_d;
  logic           perr, perr_d;
  logic           hit;
  logic           mismatch;

  // Strobe edges are registered: one edge to detect, one edge for the FSM to act
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q  <= 1'b0;
      sample_q <= 1'b0;
      lrise    <= 1'b0;
      srise    <= 1'b0;
      sfall    <= 1'b0;
    end else begin
      latch_q  <= bus.latch_en;
      sample_q <= bus.sample;
      lrise    <= bus.latch_en & ~latch_q;
      srise    <= bus.sample & ~sample_q;
      sfall    <= ~bus.sample & sample_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state: capture arms, sample reports, sample fall returns to zero
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (lrise) state_d = ARMED;
      ARMED:   if (srise) state_d = REPORT;
      REPORT:  if (sfall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mismatch = (bus.data_in != main);

  // Datapath and rail next values; strobes out of order only raise protocol_err
  always_comb begin
    main_d = main;
    late_d = late;
    err0_d = err0;
    err1_d = err1;
    perr_d = perr;
    hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (lrise) begin
          main_d = bus.data_in;
          late_d = 1'b0;
        end
        // A sample rise here (alone or together with the latch) has nothing to check
        if (srise) perr_d = 1'b1;
      end
      ARMED: begin
        if (mismatch) late_d = 1'b1;
        if (srise) begin
          hit    = late | mismatch;
          err1_d = hit;
          err0_d = ~hit;
          if (hit) main_d = bus.data_in;
        end
        if (lrise) perr_d = 1'b1;
      end
      REPORT: begin
        if (sfall) begin
          err0_d = 1'b0;
          err1_d = 1'b0;
        end
        if (lrise | srise) perr_d = 1'b1;
      end
      default: begin
        err0_d = 1'b0;
        err1_d = 1'b0;
      end
    endcase
  end

  // Datapath and rail registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main <= '0;
      late <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      perr <= 1'b0;
    end else begin
      main <= main_d;
      late <= late_d;
      err0 <= err0_d;
      err1 <= err1_d;
      perr <= perr_d;
    end
  end

  assign bus.data_out     = main;
  assign bus.err0         = err0;
  assign bus.err1         = err1;
  assign bus.protocol_err = perr;

`ifdef EDL_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of corrected timing errors
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (hit && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign bus.err_count = cnt;
`else
  assign bus.err_count = '0;
`endif

endmodule
